// File: rtl/divu_x6y3_seq_pkg.sv
// Shared configuration for the 6/3 unsigned divider. The multiplier beside it
// uses the same widths and ready convention.
// Contents: width defaults, counter width, FSM state encoding, ready levels.
package divu_x6y3_seq_pkg;

    localparam int unsigned P_WIDTH = 6;        // dividend width (multiplier product width)
    localparam int unsigned Y_WIDTH = 3;        // divisor width (multiplier Y width)
    localparam int unsigned Q_WIDTH = P_WIDTH;  // quotient width; remainder uses Y_WIDTH
    localparam int unsigned CNT_W   = $clog2(P_WIDTH);

    localparam logic READY_TRUE  = 1'b1;
    localparam logic READY_FALSE = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/divu_x6y3_seq_if.sv
// Handshake and data bundle for the divider.
// master: drives start/p/y, observes q/r/dz/rdy/valid (requester side).
// slave:  the divider itself.
interface divu_x6y3_seq_if;
    import divu_x6y3_seq_pkg::*;

    logic               start;
    logic [P_WIDTH-1:0] p;
    logic [Y_WIDTH-1:0] y;
    logic [Q_WIDTH-1:0] q;
    logic [Y_WIDTH-1:0] r;
    logic               dz;
    logic               rdy;
    logic               valid;

    modport master (
        output start, p, y,
        input  q, r, dz, rdy, valid
    );

    modport slave (
        input  start, p, y,
        output q, r, dz, rdy, valid
    );

endinterface

// File: rtl/divu_x6y3_seq_step.sv
// divu_step: one combinational restoring-division step.
// Ports:
//   rem      - current partial remainder (Y_WIDTH+1 bits)
//   dvd_bit  - next dividend bit shifted in
//   divisor  - divisor
//   rem_next - partial remainder after this step
//   q_bit    - quotient bit produced by this step
module divu_step
    import divu_x6y3_seq_pkg::*;
(
    input  logic [Y_WIDTH:0]   rem,
    input  logic               dvd_bit,
    input  logic [Y_WIDTH-1:0] divisor,
    output logic [Y_WIDTH:0]   rem_next,
    output logic               q_bit
);

    logic [Y_WIDTH:0] trial;
    logic [Y_WIDTH:0] diff;

    always_comb begin
        trial = {rem[Y_WIDTH-1:0], dvd_bit};
        diff  = trial - {1'b0, divisor};
        // rem stays below the divisor, so its top bit is always clear; folding it
        // in keeps the step correct for any input rather than silently dropping it.
        q_bit    = rem[Y_WIDTH] | (trial >= {1'b0, divisor});
        rem_next = q_bit ? diff : trial;
    end

endmodule

// File: rtl/divu_x6y3_seq.sv
// Sequential unsigned restoring divider: 6-bit dividend / 3-bit divisor,
// one quotient bit per clock, start/rdy/valid handshake.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of divu_x6y3_seq_if:
//           start/p/y in; q/r/dz registered results, rdy, one-cycle valid out
// Divide-by-zero returns q=all ones, r=0, dz=1 one cycle after start.
module divu_x6y3_seq
    import divu_x6y3_seq_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    divu_x6y3_seq_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_WIDTH-1:0] dvd_q, dvd_d;   // dividend, consumed MSB first
    logic [Y_WIDTH-1:0] dvs_q, dvs_d;
    logic [Y_WIDTH:0]   rem_q, rem_d;
    logic [Q_WIDTH-1:0] quo_q, quo_d;   // quotient being assembled
    logic [Q_WIDTH-1:0] q_q, q_d;
    logic [Y_WIDTH-1:0] r_q, r_d;
    logic               dz_q, dz_d;

    logic [Y_WIDTH:0]   step_rem;
    logic               step_qbit;

    divu_step u_step (
        .rem      (rem_q),
        .dvd_bit  (dvd_q[P_WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        unique case (state_q)
            // DONE accepts a start exactly like IDLE so operations can run back to back.
            StIdle, StDone: begin
                if (bus.start) begin
                    if (bus.y != '0) begin
                        dvd_d   = bus.p;
                        dvs_d   = bus.y;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CNT_W'(P_WIDTH - 1);
                        state_d = StRun;
                    end else begin
                        q_d     = '1;
                        r_d     = '0;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                rem_d = step_rem;
                quo_d = {quo_q[Q_WIDTH-2:0], step_qbit};
                dvd_d = dvd_q << 1;
                if (cnt_q == '0) begin
                    // Publish on the last step so q/r hold steady through RUN.
                    q_d     = {quo_q[Q_WIDTH-2:0], step_qbit};
                    r_d     = step_rem[Y_WIDTH-1:0];
                    dz_d    = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.r     = r_q;
    assign bus.dz    = dz_q;
    assign bus.valid = (state_q == StDone);
    assign bus.rdy   = (state_q == StRun) ? READY_FALSE : READY_TRUE;

endmodule

// File: tb/tb_divu_x6y3_seq.sv
// Directed self-checking bench for divu_x6y3_seq.
module tb_divu_x6y3_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    divu_x6y3_seq_if bus ();

    divu_x6y3_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation starting from a point away from the rising edge and
    // wait (bounded) for valid. lat counts negedges after the accepting edge.
    task automatic do_op(input logic [5:0] pp, input logic [2:0] yy,
                         output logic [5:0] oq, output logic [2:0] orr,
                         output logic odz, output int lat);
        bus.start = 1'b1;
        bus.p     = pp;
        bus.y     = yy;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (lat == 0) begin
            n_err++;
            $display("FAIL timeout p=%0d y=%0d: no valid within 20 cycles", pp, yy);
        end
        oq  = bus.q;
        orr = bus.r;
        odz = bus.dz;
    endtask

    task automatic test_reset();
        logic [5:0] oq;
        logic [2:0] orr;
        logic       odz;
        int         lat;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp += 5;
        if (bus.q !== 6'd0)    begin n_err++; $display("FAIL reset_q got %0d want 0", bus.q); end
        if (bus.r !== 3'd0)    begin n_err++; $display("FAIL reset_r got %0d want 0", bus.r); end
        if (bus.dz !== 1'b0)   begin n_err++; $display("FAIL reset_dz got %b want 0", bus.dz); end
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        if (bus.rdy !== 1'b1)  begin n_err++; $display("FAIL reset_rdy got %b want 1", bus.rdy); end
        rst_n = 1'b1;
        @(negedge clk);

        // Leave a nonzero result behind so the reset clearing is visible.
        do_op(6'd63, 3'd1, oq, orr, odz, lat);
        n_cmp++;
        if (oq !== 6'd63) begin n_err++; $display("FAIL pre_reset_q got %0d want 63", oq); end

        @(negedge clk);
        bus.start = 1'b1;
        bus.p     = 6'd42;
        bus.y     = 3'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL run_rdy got %b want 0", bus.rdy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (bus.q !== 6'd0)    begin n_err++; $display("FAIL midrst_q got %0d want 0", bus.q); end
        if (bus.r !== 3'd0)    begin n_err++; $display("FAIL midrst_r got %0d want 0", bus.r); end
        if (bus.dz !== 1'b0)   begin n_err++; $display("FAIL midrst_dz got %b want 0", bus.dz); end
        if (bus.rdy !== 1'b1)  begin n_err++; $display("FAIL midrst_rdy got %b want 1", bus.rdy); end
        if (bus.valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", bus.valid); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.valid !== 1'b0) begin
                n_err++;
                $display("FAIL discarded_valid cycle %0d got %b want 0", i, bus.valid);
            end
        end

        do_op(6'd42, 3'd5, oq, orr, odz, lat);
        n_cmp += 4;
        if (oq !== 6'd8)  begin n_err++; $display("FAIL fresh_q got %0d want 8", oq); end
        if (orr !== 3'd2) begin n_err++; $display("FAIL fresh_r got %0d want 2", orr); end
        if (odz !== 1'b0) begin n_err++; $display("FAIL fresh_dz got %b want 0", odz); end
        if (lat != 7)     begin n_err++; $display("FAIL fresh_latency got %0d want 7", lat); end
    endtask

    task automatic test_boundary();
        logic [5:0] tp [4] = '{6'd63, 6'd0, 6'd5, 6'd63};
        logic [2:0] ty [4] = '{3'd1, 3'd7, 3'd7, 3'd7};
        logic [5:0] eq [4] = '{6'd63, 6'd0, 6'd0, 6'd9};
        logic [2:0] er [4] = '{3'd0, 3'd0, 3'd5, 3'd0};
        logic [5:0] oq;
        logic [2:0] orr;
        logic       odz;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            do_op(tp[i], ty[i], oq, orr, odz, lat);
            n_cmp += 4;
            if (oq !== eq[i])  begin n_err++; $display("FAIL bnd_q %0d/%0d got %0d want %0d", tp[i], ty[i], oq, eq[i]); end
            if (orr !== er[i]) begin n_err++; $display("FAIL bnd_r %0d/%0d got %0d want %0d", tp[i], ty[i], orr, er[i]); end
            if (odz !== 1'b0)  begin n_err++; $display("FAIL bnd_dz %0d/%0d got %b want 0", tp[i], ty[i], odz); end
            if (lat != 7)      begin n_err++; $display("FAIL bnd_lat %0d/%0d got %0d want 7", tp[i], ty[i], lat); end
        end
    endtask

    task automatic test_div_zero();
        logic [5:0] oq;
        logic [2:0] orr;
        logic       odz;
        int         lat;
        @(negedge clk);
        do_op(6'd23, 3'd0, oq, orr, odz, lat);
        n_cmp += 4;
        if (oq !== 6'h3F) begin n_err++; $display("FAIL dz_q got %0h want 3f", oq); end
        if (orr !== 3'd0) begin n_err++; $display("FAIL dz_r got %0d want 0", orr); end
        if (odz !== 1'b1) begin n_err++; $display("FAIL dz_flag got %b want 1", odz); end
        if (lat != 1)     begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
        @(negedge clk);
        do_op(6'd6, 3'd3, oq, orr, odz, lat);
        n_cmp += 3;
        if (oq !== 6'd2)  begin n_err++; $display("FAIL after_dz_q got %0d want 2", oq); end
        if (orr !== 3'd0) begin n_err++; $display("FAIL after_dz_r got %0d want 0", orr); end
        if (odz !== 1'b0) begin n_err++; $display("FAIL after_dz_flag got %b want 0", odz); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.p     = 6'd42;
        bus.y     = 3'd5;
        @(posedge clk);
        #1;
        // Keep hammering start with other operands while busy.
        bus.p = 6'd1;
        bus.y = 3'd1;
        lat   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                lat = i;
                break;
            end
            n_cmp++;
            if (bus.rdy !== 1'b0) begin n_err++; $display("FAIL busy_rdy cycle %0d got %b want 0", i, bus.rdy); end
        end
        n_cmp += 4;
        if (lat != 7)      begin n_err++; $display("FAIL busy_latency got %0d want 7", lat); end
        if (bus.q !== 6'd8) begin n_err++; $display("FAIL busy_q got %0d want 8", bus.q); end
        if (bus.r !== 3'd2) begin n_err++; $display("FAIL busy_r got %0d want 2", bus.r); end
        if (bus.rdy !== 1'b1) begin n_err++; $display("FAIL done_rdy got %b want 1", bus.rdy); end
        // start is still high in the DONE cycle: this one must be taken.
        bus.p = 6'd61;
        bus.y = 3'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                lat = i;
                break;
            end
        end
        n_cmp += 3;
        if (lat != 7)       begin n_err++; $display("FAIL b2b_latency got %0d want 7", lat); end
        if (bus.q !== 6'd15) begin n_err++; $display("FAIL b2b_q got %0d want 15", bus.q); end
        if (bus.r !== 3'd1)  begin n_err++; $display("FAIL b2b_r got %0d want 1", bus.r); end
    endtask

    task automatic test_exhaustive();
        logic [5:0] oq;
        logic [2:0] orr;
        logic       odz;
        int         lat;
        int         eq;
        int         er;
        @(negedge clk);
        for (int pi = 0; pi < 64; pi++) begin
            for (int yi = 1; yi < 8; yi++) begin
                do_op(6'(pi), 3'(yi), oq, orr, odz, lat);
                eq = pi / yi;
                er = pi % yi;
                n_cmp += 5;
                if (int'(oq) != eq)  begin n_err++; $display("FAIL exh_q %0d/%0d got %0d want %0d", pi, yi, oq, eq); end
                if (int'(orr) != er) begin n_err++; $display("FAIL exh_r %0d/%0d got %0d want %0d", pi, yi, orr, er); end
                if (int'(oq) * yi + int'(orr) != pi) begin
                    n_err++;
                    $display("FAIL exh_inv %0d/%0d got q*y+r=%0d want %0d", pi, yi, int'(oq) * yi + int'(orr), pi);
                end
                if (int'(orr) >= yi) begin n_err++; $display("FAIL exh_rlt %0d/%0d got r=%0d want <%0d", pi, yi, orr, yi); end
                if (odz !== 1'b0)    begin n_err++; $display("FAIL exh_dz %0d/%0d got %b want 0", pi, yi, odz); end
            end
        end
    endtask

    task automatic test_hold();
        logic [5:0] oq;
        logic [2:0] orr;
        logic       odz;
        int         lat;
        @(negedge clk);
        do_op(6'd42, 3'd5, oq, orr, odz, lat);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.p = 6'($urandom);
            bus.y = 3'($urandom);
            @(negedge clk);
            n_cmp += 4;
            if (bus.q !== 6'd8)     begin n_err++; $display("FAIL hold_q cycle %0d got %0d want 8", i, bus.q); end
            if (bus.r !== 3'd2)     begin n_err++; $display("FAIL hold_r cycle %0d got %0d want 2", i, bus.r); end
            if (bus.dz !== 1'b0)    begin n_err++; $display("FAIL hold_dz cycle %0d got %b want 0", i, bus.dz); end
            if (bus.valid !== 1'b0) begin n_err++; $display("FAIL hold_valid cycle %0d got %b want 0", i, bus.valid); end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        bus.start = 1'b0;
        bus.p     = '0;
        bus.y     = '0;
        test_reset();
        test_boundary();
        test_div_zero();
        test_back_to_back();
        test_exhaustive();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
